rv32imc_ss_hs_mmr_responder: RTL and testbench
==============================================

// Module: rv32imc_ss_hs_mmr_responder
// PURPOSE
//  Responder (slave) end of the rv32imc_ss req/ack data handshake. Sits on an external data_* port after upstream
//  address decode and implements the memory-mapped machine timer (mtime/mtimecmp, timer IRQ) and GPIO registers.
//  Adds programmable wait states, bus errors on bad accesses, and byte-enable writes.
// PARAMETERS
//  GPIO_N       8   number of 32-bit GPIO out/in registers (1..32)
//  WAIT_CYCLES  0   extra cycles between request accept and ack/err (0..15)
//  PRESCALE     1   clk cycles per mtime increment (>=1; 1 = every cycle)
// PORTS
//  clk            in   1          system clock, all state on rising edge
//  reset_n        in   1          asynchronous, active-low reset
//  req            in   1          initiator request; held with wr/addr/be/data_i until ack or err
//  wr             in   1          1 = write, 0 = read
//  addr           in   32         byte address; only addr[8:0] decoded (512 B window)
//  be             in   4          byte enables for writes (bit i -> data_i[8i+:8])
//  data_i         in   32         write data
//  ack            out  1          one-cycle pulse: transaction completed
//  err            out  1          one-cycle pulse: transaction rejected (never together with ack)
//  data_o         out  32         read data, valid only while ack=1, else 0
//  gpio_o         out  GPIO_Nx32  GPIO output registers
//  gpio_i         in   GPIO_Nx32  GPIO input values (sampled on read)
//  gpio_o_update  out  GPIO_N     one-cycle pulse on bit i when gpio_o[i] written
//  gpio_i_update  out  GPIO_N     one-cycle pulse on bit i when gpio_i[i] read
//  timer_irq      out  1          level: registered (mtime >= mtimecmp), unsigned 64-bit
// BEHAVIOUR
//  Register map (byte offsets): 0x000 MTIME_LO rw, 0x004 MTIME_HI rw, 0x008 MTIMECMP_LO rw, 0x00C MTIMECMP_HI rw,
//   0x010 CTRL rw (bit0 EN, others read 0), 0x014 STATUS ro (bit0 = timer_irq), 0x100+4i GPIO_OUT[i] rw,
//   0x180+4i GPIO_IN[i] ro, i < GPIO_N.
//  Reset: ack=err=0, data_o=0, gpio_o=0, both update vectors 0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF,
//   CTRL.EN=0, prescaler=0, timer_irq=0, FSM=IDLE.
//  FSM: IDLE --req--> WAIT (if WAIT_CYCLES>0, counts WAIT_CYCLES) --> RESP --> IDLE; WAIT_CYCLES=0 goes IDLE->RESP.
//   Request inputs latched on accept in IDLE; changes afterwards are ignored until back in IDLE.
//   Register write/read sample happens on the edge entering RESP; ack or err is high exactly during RESP.
//   Latency: ack 1+WAIT_CYCLES cycles after req first sampled; throughput 1 per 2+WAIT_CYCLES cycles.
//   req high in IDLE after a RESP is a new transaction.
//  Errors (err, no state change, data_o=0): addr[1:0]!=0; unmapped offset; GPIO index >= GPIO_N; write to RO reg.
//  Writes: only bytes with be[i]=1 change; be=0 write is acked with no change; gpio_o_update[i] pulses even if be=0.
//  Reads: data_o = register value; GPIO_IN read returns gpio_i[i] sampled at the RESP-entry edge, pulses gpio_i_update[i].
//  Timer: when EN, prescaler counts 0..PRESCALE-1, mtime += 1 on wrap; 64-bit wrap-around to 0 allowed.
//   Write to MTIME_LO/HI in a cycle suppresses that cycle's increment (write wins, prescaler unaffected).
//   No carry handling between halves on writes; software writes LO then HI.
//   timer_irq recomputed every cycle from registered values (1-cycle delay), independent of EN; cleared by
//   raising mtimecmp.
//  Reset mid-transaction: FSM returns to IDLE, no ack/err issued, in-flight write not performed.
// STRUCTURE
//  Shared package rv32imc_ss_pkg: register offset localparams, state enum {IDLE, WAIT, RESP}, CTRL bit indices.
//  Sub-module rv32imc_ss_timer64: prescaler + mtime/mtimecmp with byte-enable write ports and timer_irq compare.
// TESTING
//  Read 0x014 after reset, WAIT_CYCLES=0 -> ack one cycle after req, data_o=0, timer_irq=0.
//  Write 0x104 data 0xAABBCCDD be=4'b0101 -> gpio_o[1]=0x00BB00DD, gpio_o_update=8'b0000_0010 for one cycle.
//  Write 0x180 (RO), read 0x002 (misaligned), read 0x1A0 with GPIO_N=8 -> err pulse each, no ack, no state change.
//  CTRL.EN=1, PRESCALE=4, MTIMECMP_LO=10, HI=0 -> timer_irq rises 41..42 cycles after EN; MTIMECMP_HI=1 -> falls.
//  MTIME_LO=0xFFFF_FFFF, HI=0xFFFF_FFFF, EN=1, PRESCALE=1 -> mtime wraps to 0; write MTIME_LO mid-count -> no increment.
//  WAIT_CYCLES=3, back-to-back reads with req held -> ack every 5 cycles; reset_n low in WAIT -> no ack, FSM in IDLE.

Source files
------------

// File: rtl/rv32imc_ss_pkg.sv
// rtl/rv32imc_ss_pkg.sv - register map, FSM states and byte-merge helper for the MMR responder
package rv32imc_ss_pkg;

  localparam logic [8:0] OFF_MTIME_LO    = 9'h000;
  localparam logic [8:0] OFF_MTIME_HI    = 9'h004;
  localparam logic [8:0] OFF_MTIMECMP_LO = 9'h008;
  localparam logic [8:0] OFF_MTIMECMP_HI = 9'h00C;
  localparam logic [8:0] OFF_CTRL        = 9'h010;
  localparam logic [8:0] OFF_STATUS      = 9'h014;
  localparam logic [8:0] OFF_GPIO_OUT    = 9'h100;
  localparam logic [8:0] OFF_GPIO_IN     = 9'h180;

  localparam int CTRL_EN    = 0;
  localparam int STATUS_IRQ = 0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_TIMER, SEL_CTRL, SEL_STATUS, SEL_GPIO_OUT, SEL_GPIO_IN
  } sel_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32imc_ss_hs_mmr_responder_if.sv
// rtl/rv32imc_ss_hs_mmr_responder_if.sv - req/ack data handshake between initiator and responder
interface rv32imc_ss_hs_mmr_responder_if;

  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] data_i;
  logic        ack;
  logic        err;
  logic [31:0] data_o;

  modport master (output req, wr, addr, be, data_i, input ack, err, data_o);
  modport slave  (input req, wr, addr, be, data_i, output ack, err, data_o);

endinterface

// File: rtl/rv32imc_ss_timer64.sv
// rtl/rv32imc_ss_timer64.sv - prescaled 64-bit mtime/mtimecmp with byte-enable writes and timer irq
module rv32imc_ss_timer64 import rv32imc_ss_pkg::*; #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [3:0]  we,        // {cmp_hi, cmp_lo, mtime_hi, mtime_lo}
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = en && (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      if (en) pre <= tick ? '0 : pre + 1'b1;
      // A software write to either mtime half owns that cycle; the tick is dropped.
      if (we[0] || we[1]) begin
        if (we[0]) mtime[31:0]  <= be_merge(mtime[31:0], wdata, be);
        if (we[1]) mtime[63:32] <= be_merge(mtime[63:32], wdata, be);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (we[2]) mtimecmp[31:0]  <= be_merge(mtimecmp[31:0], wdata, be);
      if (we[3]) mtimecmp[63:32] <= be_merge(mtimecmp[63:32], wdata, be);
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/rv32imc_ss_hs_mmr_responder.sv
// rtl/rv32imc_ss_hs_mmr_responder.sv - responder for machine timer and GPIO registers with wait states and bus errors
module rv32imc_ss_hs_mmr_responder import rv32imc_ss_pkg::*; #(
  parameter int GPIO_N      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int PRESCALE    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  rv32imc_ss_hs_mmr_responder_if.slave bus,
  output logic [GPIO_N-1:0][31:0] gpio_o,
  input  logic [GPIO_N-1:0][31:0] gpio_i,
  output logic [GPIO_N-1:0]       gpio_o_update,
  output logic [GPIO_N-1:0]       gpio_i_update,
  output logic                    timer_irq
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  wcnt;
  logic        l_wr;
  logic [8:0]  l_addr;
  logic [3:0]  l_be;
  logic [31:0] l_data;
  logic        resp_err;
  logic [31:0] rdata_q;
  logic        ctrl_en;

  logic        cur_wr;
  logic [8:0]  cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_data;
  logic [4:0]  gidx;
  sel_t        sel;
  logic        bad, enter, go;
  logic [31:0] rdata;
  logic [3:0]  t_we;
  logic [63:0] mtime, mtimecmp;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:9];

  // In IDLE the live bus is decoded so a zero-wait access can complete on the accept edge.
  assign cur_wr   = (state == IDLE) ? bus.wr          : l_wr;
  assign cur_addr = (state == IDLE) ? bus.addr[8:0]   : l_addr;
  assign cur_be   = (state == IDLE) ? bus.be          : l_be;
  assign cur_data = (state == IDLE) ? bus.data_i      : l_data;
  assign gidx     = cur_addr[6:2];

  always_comb begin
    sel = SEL_NONE;
    case (cur_addr)
      OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP_LO, OFF_MTIMECMP_HI: sel = SEL_TIMER;
      OFF_CTRL:   sel = SEL_CTRL;
      OFF_STATUS: sel = SEL_STATUS;
      default: begin
        if (cur_addr[8:7] == OFF_GPIO_OUT[8:7] && int'(gidx) < GPIO_N) sel = SEL_GPIO_OUT;
        else if (cur_addr[8:7] == OFF_GPIO_IN[8:7] && int'(gidx) < GPIO_N) sel = SEL_GPIO_IN;
      end
    endcase
  end

  assign bad   = (cur_addr[1:0] != 2'b00) || (sel == SEL_NONE) ||
                 (cur_wr && (sel == SEL_STATUS || sel == SEL_GPIO_IN));
  assign enter = (next_state == RESP);
  assign go    = enter && !bad;
  assign t_we  = (go && cur_wr && sel == SEL_TIMER) ? (4'b0001 << cur_addr[3:2]) : 4'b0000;

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_TIMER: begin
        case (cur_addr[3:2])
          2'd0:    rdata = mtime[31:0];
          2'd1:    rdata = mtime[63:32];
          2'd2:    rdata = mtimecmp[31:0];
          default: rdata = mtimecmp[63:32];
        endcase
      end
      SEL_CTRL:   rdata[CTRL_EN]    = ctrl_en;
      SEL_STATUS: rdata[STATUS_IRQ] = timer_irq;
      SEL_GPIO_OUT: for (int i = 0; i < GPIO_N; i++) if (gidx == 5'(i)) rdata = gpio_o[i];
      SEL_GPIO_IN:  for (int i = 0; i < GPIO_N; i++) if (gidx == 5'(i)) rdata = gpio_i[i];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= next_state;
      wcnt  <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (wcnt == WAIT_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ack    = (state == RESP) && !resp_err;
    bus.err    = (state == RESP) && resp_err;
    bus.data_o = bus.ack ? rdata_q : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_wr   <= 1'b0;
      l_addr <= '0;
      l_be   <= '0;
      l_data <= '0;
    end else if (state == IDLE && bus.req) begin
      l_wr   <= bus.wr;
      l_addr <= bus.addr[8:0];
      l_be   <= bus.be;
      l_data <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_err      <= 1'b0;
      rdata_q       <= '0;
      ctrl_en       <= 1'b0;
      gpio_o        <= '0;
      gpio_o_update <= '0;
      gpio_i_update <= '0;
    end else begin
      gpio_o_update <= '0;
      gpio_i_update <= '0;
      if (enter) begin
        resp_err <= bad;
        rdata_q  <= (go && !cur_wr) ? rdata : 32'd0;
      end
      if (go && cur_wr && sel == SEL_CTRL && cur_be[CTRL_EN / 8]) ctrl_en <= cur_data[CTRL_EN];
      for (int i = 0; i < GPIO_N; i++) begin
        if (go && gidx == 5'(i)) begin
          if (sel == SEL_GPIO_OUT && cur_wr) begin
            gpio_o[i]        <= be_merge(gpio_o[i], cur_data, cur_be);
            gpio_o_update[i] <= 1'b1;
          end
          if (sel == SEL_GPIO_IN) gpio_i_update[i] <= 1'b1;
        end
      end
    end
  end

  rv32imc_ss_timer64 #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (ctrl_en),
    .we        (t_we),
    .be        (cur_be),
    .wdata     (cur_data),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .timer_irq (timer_irq)
  );

endmodule

// File: tb/tb_rv32imc_ss_hs_mmr_responder.sv
// tb/tb_rv32imc_ss_hs_mmr_responder.sv - directed scoreboard bench: dut0 zero-wait/prescale 4, dut1 three-wait/prescale 1
module tb_rv32imc_ss_hs_mmr_responder;
  import rv32imc_ss_pkg::*;

  typedef struct {logic err; logic [31:0] data;} exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0][31:0] gpio_o0, gpio_o1, gpio_i0, gpio_i1;
  logic [7:0] upd_o0, upd_i0, upd_o1, upd_i1;
  logic irq0, irq1;
  exp_t sb[$];
  int ncomp = 0;
  int nfail = 0;
  int lat, cnt;

  rv32imc_ss_hs_mmr_responder_if b0();
  rv32imc_ss_hs_mmr_responder_if b1();

  rv32imc_ss_hs_mmr_responder #(.GPIO_N(8), .WAIT_CYCLES(0), .PRESCALE(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .gpio_o(gpio_o0), .gpio_i(gpio_i0),
    .gpio_o_update(upd_o0), .gpio_i_update(upd_i0), .timer_irq(irq0));

  rv32imc_ss_hs_mmr_responder #(.GPIO_N(8), .WAIT_CYCLES(3), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1), .gpio_o(gpio_o1), .gpio_i(gpio_i1),
    .gpio_o_update(upd_o1), .gpio_i_update(upd_i1), .timer_irq(irq1));

  always #5 clk = ~clk;

  function automatic logic ack_of(input int d);
    return (d == 0) ? b0.ack : b1.ack;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? b0.err : b1.err;
  endfunction
  function automatic logic [31:0] dout_of(input int d);
    return (d == 0) ? b0.data_o : b1.data_o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] dat);
    if (d == 0) begin
      b0.req = r; b0.wr = w; b0.addr = a; b0.be = b; b0.data_i = dat;
    end else begin
      b1.req = r; b1.wr = w; b1.addr = a; b1.be = b; b1.data_i = dat;
    end
  endtask

  // Returns on the negedge where ack/err is visible, with req already dropped.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] dat, input logic e_err, input logic [31:0] e_dat,
                     output int latency);
    exp_t e;
    bit got;
    int n;
    sb.push_back('{e_err, e_dat});
    drive(d, 1'b1, w, a, b, dat);
    got = 1'b0;
    n = 0;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      got = ack_of(d) | err_of(d);
    end
    drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    e = sb.pop_front();
    latency = n;
    check("resp_seen", 64'(got), 64'd1);
    check("err", 64'(err_of(d)), 64'(e.err));
    check("ack", 64'(ack_of(d)), 64'(!e.err));
    check("data_o", 64'(dout_of(d)), 64'(e.data));
  endtask

  initial begin
    gpio_i0 = '0;
    gpio_i1 = '0;
    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(b0.ack), 64'd0);
    check("rst_err", 64'(b0.err), 64'd0);
    check("rst_data_o", 64'(b0.data_o), 64'd0);
    check("rst_gpio_o", 64'(gpio_o0[0]), 64'd0);
    check("rst_irq", 64'(irq0), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // zero-wait status read
    txn(0, 1'b0, 32'h014, 4'hF, 32'd0, 1'b0, 32'd0, lat);
    check("lat_w0", 64'(lat), 64'd1);
    check("irq_idle", 64'(irq0), 64'd0);

    // partial-byte GPIO write
    txn(0, 1'b1, 32'h104, 4'b0101, 32'hAABBCCDD, 1'b0, 32'd0, lat);
    check("gpio_o1_val", 64'(gpio_o0[1]), 64'h00BB00DD);
    check("gpio_o_upd", 64'(upd_o0), 64'h02);
    @(negedge clk);
    check("gpio_o_upd_clr", 64'(upd_o0), 64'h00);
    txn(0, 1'b1, 32'h108, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'd0, lat);
    check("be0_no_change", 64'(gpio_o0[2]), 64'd0);
    check("be0_upd", 64'(upd_o0), 64'h04);

    // error cases
    txn(0, 1'b1, 32'h180, 4'hF, 32'h1234, 1'b1, 32'd0, lat);
    check("ro_wr_no_upd", 64'(upd_o0), 64'd0);
    txn(0, 1'b0, 32'h002, 4'hF, 32'd0, 1'b1, 32'd0, lat);
    txn(0, 1'b0, 32'h1A0, 4'hF, 32'd0, 1'b1, 32'd0, lat);
    txn(0, 1'b1, 32'h014, 4'hF, 32'hFFFFFFFF, 1'b1, 32'd0, lat);
    txn(0, 1'b0, 32'h020, 4'hF, 32'd0, 1'b1, 32'd0, lat);
    txn(0, 1'b1, 32'h105, 4'hF, 32'h0, 1'b1, 32'd0, lat);
    txn(0, 1'b0, 32'h104, 4'hF, 32'd0, 1'b0, 32'h00BB00DD, lat);

    // GPIO input sampling
    gpio_i0[3] = 32'h12345678;
    txn(0, 1'b0, 32'h18C, 4'hF, 32'd0, 1'b0, 32'h12345678, lat);
    check("gpio_i_upd", 64'(upd_i0), 64'h08);

    // timer compare with prescale 4
    txn(0, 1'b1, 32'h008, 4'hF, 32'd10, 1'b0, 32'd0, lat);
    txn(0, 1'b1, 32'h00C, 4'hF, 32'd0, 1'b0, 32'd0, lat);
    txn(0, 1'b0, 32'h008, 4'hF, 32'd0, 1'b0, 32'd10, lat);
    txn(0, 1'b0, 32'h010, 4'hF, 32'd0, 1'b0, 32'd0, lat);
    txn(0, 1'b1, 32'h010, 4'hF, 32'd1, 1'b0, 32'd0, lat);
    cnt = 0;
    while (!irq0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("irq_rise_41_42", 64'(cnt == 41 || cnt == 42), 64'd1);
    txn(0, 1'b0, 32'h014, 4'hF, 32'd0, 1'b0, 32'd1, lat);
    txn(0, 1'b0, 32'h010, 4'hF, 32'd0, 1'b0, 32'd1, lat);
    txn(0, 1'b1, 32'h00C, 4'hF, 32'd1, 1'b0, 32'd0, lat);
    repeat (2) @(negedge clk);
    check("irq_fall", 64'(irq0), 64'd0);

    // 64-bit wrap and write-suppressed increment on dut1
    txn(1, 1'b1, 32'h000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'd0, lat);
    check("lat_w3", 64'(lat), 64'd4);
    txn(1, 1'b1, 32'h004, 4'hF, 32'hFFFFFFFF, 1'b0, 32'd0, lat);
    txn(1, 1'b0, 32'h004, 4'hF, 32'd0, 1'b0, 32'hFFFFFFFF, lat);
    check("irq_at_max", 64'(irq1), 64'd1);
    txn(1, 1'b1, 32'h010, 4'hF, 32'd1, 1'b0, 32'd0, lat);
    txn(1, 1'b0, 32'h000, 4'hF, 32'd0, 1'b0, 32'd3, lat);
    txn(1, 1'b0, 32'h004, 4'hF, 32'd0, 1'b0, 32'd0, lat);
    check("irq_after_wrap", 64'(irq1), 64'd0);
    txn(1, 1'b1, 32'h000, 4'hF, 32'h100, 1'b0, 32'd0, lat);
    txn(1, 1'b0, 32'h000, 4'hF, 32'd0, 1'b0, 32'h104, lat);

    // back-to-back reads with req held
    txn(1, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D, 1'b0, 32'd0, lat);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 32'hCAFEF00D});
    drive(1, 1'b1, 1'b0, 32'h100, 4'hF, 32'd0);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      check("b2b_ack", 64'(b1.ack), 64'(i >= 4 && (i - 4) % 5 == 0));
      if (b1.ack && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("b2b_data", 64'(b1.data_o), 64'(e.data));
      end
    end
    check("b2b_left", 64'(sb.size()), 64'd0);

    // reset while dut1 sits in WAIT
    check("pre_rst_wait", 64'(dut1.state), 64'(WAIT));
    drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_state_idle", 64'(dut1.state), 64'(IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b1.ack || b1.err) cnt++;
    end
    check("rst_no_resp", 64'(cnt), 64'd0);
    check("rst_gpio_o0", 64'(gpio_o0[1]), 64'd0);
    txn(0, 1'b0, 32'h00C, 4'hF, 32'd0, 1'b0, 32'hFFFFFFFF, lat);
    txn(0, 1'b0, 32'h010, 4'hF, 32'd0, 1'b0, 32'd0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
